// File: rtl/octant_pkg.sv
// -----------------------------------------------------------------------------
// octant_pkg
// Shared constants and helpers for the octant reduction pipeline.
//   FLAG_*      : bit positions inside the 3-bit octant flag {swap, re_neg, im_neg}
//   calc_lat()  : input-to-output latency in enabled cycles
//   sat_ratio() : largest representable Q0.frac_w ratio
// Optional feature macro: OCTANT_ROUND_EN (one extra quotient bit, round-half-up).
// -----------------------------------------------------------------------------
package octant_pkg;

    localparam int FLAG_W      = 3;
    localparam int FLAG_SWAP   = 2;
    localparam int FLAG_RE_NEG = 1;
    localparam int FLAG_IM_NEG = 0;

    // Stage 0 + one stage per quotient bit + output register.
    function automatic int calc_lat(input int frac_w);
`ifdef OCTANT_ROUND_EN
        return frac_w + 3;
`else
        return frac_w + 2;
`endif
    endfunction

    function automatic int sat_ratio(input int frac_w);
        return (1 << frac_w) - 1;
    endfunction

endpackage

// File: rtl/octant_div_stage.sv
// -----------------------------------------------------------------------------
// octant_div_stage
// One restoring-division step: doubles the remainder, subtracts the divisor
// when it fits and shifts the resulting quotient bit into the partial quotient.
// Flags, divisor and valid ride along unchanged. Everything holds when i_en=0.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_en              : pipeline advance enable
//   i_val/o_val       : sample valid
//   i_rem/o_rem       : partial remainder (DATA_W+1 bits)
//   i_den/o_den       : divisor (DATA_W bits)
//   i_q/o_q           : partial quotient, MSB-first (Q_W bits)
//   i_flag/o_flag     : octant flag
// -----------------------------------------------------------------------------
module octant_div_stage
    import octant_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int Q_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_val,
    input  logic [DATA_W:0]   i_rem,
    input  logic [DATA_W-1:0] i_den,
    input  logic [Q_W-1:0]    i_q,
    input  logic [FLAG_W-1:0] i_flag,
    output logic              o_val,
    output logic [DATA_W:0]   o_rem,
    output logic [DATA_W-1:0] o_den,
    output logic [Q_W-1:0]    o_q,
    output logic [FLAG_W-1:0] o_flag
);

    logic [DATA_W:0] w_rem2;
    logic [DATA_W:0] w_den_ext;
    logic            w_ge;

    // The remainder never exceeds den <= 2^(DATA_W-1), so doubling it cannot
    // overflow DATA_W+1 bits and the shift discards only a zero.
    assign w_rem2    = i_rem << 1;
    assign w_den_ext = {1'b0, i_den};
    assign w_ge      = (w_rem2 >= w_den_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_val  <= 1'b0;
            o_rem  <= '0;
            o_den  <= '0;
            o_q    <= '0;
            o_flag <= '0;
        end else if (i_en) begin
            o_val  <= i_val;
            o_rem  <= w_ge ? (w_rem2 - w_den_ext) : w_rem2;
            o_den  <= i_den;
            o_q    <= (i_q << 1) | Q_W'(w_ge);
            o_flag <= i_flag;
        end
    end

endmodule

// File: rtl/octant_reduce_pipe.sv
// -----------------------------------------------------------------------------
// octant_reduce_pipe
// Folds a signed complex sample into the first half-octant and emits the ratio
// min(|re|,|im|)/max(|re|,|im|) as unsigned Q0.FRAC_W plus a 3-bit octant
// flag {swap, re_neg, im_neg}. Fully pipelined with one restoring-division
// stage per quotient bit and a single global enable for backpressure.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   val_i / rdy_o   : input handshake
//   real_i, imag_i  : signed sample (DATA_W bits)
//   val_o / rdy_i   : output handshake
//   into_atan_poly  : ratio, unsigned Q0.FRAC_W
//   case_flag       : octant flag {swap, re_neg, im_neg}
// Optional feature macro: OCTANT_ROUND_EN (FRAC_W+1 quotient bits, ratio
// rounded half-up, latency FRAC_W+3 instead of FRAC_W+2).
// -----------------------------------------------------------------------------
module octant_reduce_pipe
    import octant_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     val_i,
    output logic                     rdy_o,
    input  logic signed [DATA_W-1:0] real_i,
    input  logic signed [DATA_W-1:0] imag_i,
    output logic                     val_o,
    input  logic                     rdy_i,
    output logic [FRAC_W-1:0]        into_atan_poly,
    output logic [FLAG_W-1:0]        case_flag
);

    localparam int LAT    = calc_lat(FRAC_W);
    localparam int NSTAGE = LAT - 2;    // divider stages == quotient bits

    // ---------------- global enable ----------------
    logic w_en;
    assign w_en  = rdy_i | ~val_o;
    assign rdy_o = w_en;

    // ---------------- stage 0: magnitude / compare ----------------
    logic [DATA_W-1:0] w_re_u, w_im_u;
    logic [DATA_W-1:0] w_am, w_bm, w_num, w_den0;
    logic              w_swap;
    logic [FLAG_W-1:0] w_flag0;

    assign w_re_u = real_i;
    assign w_im_u = imag_i;
    // Unsigned DATA_W-bit magnitude: the most negative input becomes
    // 2^(DATA_W-1) without wrapping.
    assign w_am   = w_re_u[DATA_W-1] ? (~w_re_u + DATA_W'(1)) : w_re_u;
    assign w_bm   = w_im_u[DATA_W-1] ? (~w_im_u + DATA_W'(1)) : w_im_u;
    assign w_swap = (w_bm > w_am);
    assign w_num  = w_swap ? w_am : w_bm;
    assign w_den0 = w_swap ? w_bm : w_am;

    always_comb begin
        w_flag0              = '0;
        w_flag0[FLAG_SWAP]   = w_swap;
        w_flag0[FLAG_RE_NEG] = w_re_u[DATA_W-1];
        w_flag0[FLAG_IM_NEG] = w_im_u[DATA_W-1];
    end

    logic              r_s0_val;
    logic [DATA_W:0]   r_s0_rem;
    logic [DATA_W-1:0] r_s0_den;
    logic [FLAG_W-1:0] r_s0_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_val  <= 1'b0;
            r_s0_rem  <= '0;
            r_s0_den  <= '0;
            r_s0_flag <= '0;
        end else if (w_en) begin
            r_s0_val  <= val_i;
            r_s0_rem  <= {1'b0, w_num};
            r_s0_den  <= w_den0;
            r_s0_flag <= w_flag0;
        end
    end

    // ---------------- divider chain ----------------
    logic              w_val  [0:NSTAGE];
    logic [DATA_W:0]   w_rem  [0:NSTAGE];
    logic [DATA_W-1:0] w_den  [0:NSTAGE];
    logic [NSTAGE-1:0] w_q    [0:NSTAGE];
    logic [FLAG_W-1:0] w_flag [0:NSTAGE];

    assign w_val[0]  = r_s0_val;
    assign w_rem[0]  = r_s0_rem;
    assign w_den[0]  = r_s0_den;
    assign w_q[0]    = '0;
    assign w_flag[0] = r_s0_flag;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_div
            octant_div_stage #(
                .DATA_W (DATA_W),
                .Q_W    (NSTAGE)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_en),
                .i_val  (w_val[gi]),
                .i_rem  (w_rem[gi]),
                .i_den  (w_den[gi]),
                .i_q    (w_q[gi]),
                .i_flag (w_flag[gi]),
                .o_val  (w_val[gi+1]),
                .o_rem  (w_rem[gi+1]),
                .o_den  (w_den[gi+1]),
                .o_q    (w_q[gi+1]),
                .o_flag (w_flag[gi+1])
            );
        end
    endgenerate

    // ---------------- ratio formation ----------------
    logic [FRAC_W-1:0] w_ratio;

`ifdef OCTANT_ROUND_EN
    localparam logic [FRAC_W-1:0] SAT = FRAC_W'(sat_ratio(FRAC_W));

    logic [NSTAGE:0]   w_sum;
    logic [NSTAGE-1:0] w_half;

    // (q+1)>>1 over FRAC_W+1 quotient bits; a carry into bit FRAC_W means the
    // rounded ratio reached 1.0 and is clamped.
    assign w_sum   = {1'b0, w_q[NSTAGE]} + (NSTAGE+1)'(1);
    assign w_half  = NSTAGE'(w_sum >> 1);
    assign w_ratio = w_half[FRAC_W] ? SAT : w_half[FRAC_W-1:0];
`else
    // When num == den the restoring chain yields all ones, which is already
    // the saturated value of the ideal quotient 2^FRAC_W.
    assign w_ratio = w_q[NSTAGE];
`endif

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_o          <= 1'b0;
            into_atan_poly <= '0;
            case_flag      <= '0;
        end else if (w_en) begin
            val_o <= w_val[NSTAGE];
            // A zero divisor means a zero input; the chain would otherwise
            // report all ones.
            if (w_den[NSTAGE] == '0) begin
                into_atan_poly <= '0;
                case_flag      <= '0;
            end else begin
                into_atan_poly <= w_ratio;
                case_flag      <= w_flag[NSTAGE];
            end
        end
    end

endmodule

// File: tb/tb_octant_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_octant_reduce_pipe
// Directed corner samples, a 1024-sample backpressured stream checked against
// an arithmetic reference model through an in-order queue, and an
// asynchronous reset flush with samples in flight.
// -----------------------------------------------------------------------------
module tb_octant_reduce_pipe;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 8;
`ifdef OCTANT_ROUND_EN
    localparam int LAT_EXP = FRAC_W + 3;
`else
    localparam int LAT_EXP = FRAC_W + 2;
`endif
    localparam int N_STREAM = 1024;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     val_i = 1'b0;
    logic                     rdy_i = 1'b0;
    logic signed [DATA_W-1:0] real_i = '0;
    logic signed [DATA_W-1:0] imag_i = '0;
    logic                     rdy_o;
    logic                     val_o;
    logic [FRAC_W-1:0]        into_atan_poly;
    logic [2:0]               case_flag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]        flag;
        logic [FRAC_W-1:0] ratio;
    } exp_t;

    exp_t sb[$];

    octant_reduce_pipe #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .val_i          (val_i),
        .rdy_o          (rdy_o),
        .real_i         (real_i),
        .imag_i         (imag_i),
        .val_o          (val_o),
        .rdy_i          (rdy_i),
        .into_atan_poly (into_atan_poly),
        .case_flag      (case_flag)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the folded magnitudes.
    function automatic exp_t model(input logic signed [DATA_W-1:0] re,
                                   input logic signed [DATA_W-1:0] im);
        int   a, b, num, den, q;
        exp_t e;
        a = (re < 0) ? -int'(re) : int'(re);
        b = (im < 0) ? -int'(im) : int'(im);
        num = (b > a) ? a : b;
        den = (b > a) ? b : a;
        e = '0;
        if (den == 0) return e;
        e.flag = {(b > a), (re < 0), (im < 0)};
`ifdef OCTANT_ROUND_EN
        q = (num << (FRAC_W + 1)) / den;
        q = (q + 1) >> 1;
`else
        q = (num << FRAC_W) / den;
`endif
        if (q > (1 << FRAC_W) - 1) q = (1 << FRAC_W) - 1;
        e.ratio = q[FRAC_W-1:0];
        return e;
    endfunction

    function automatic logic signed [DATA_W-1:0] rand_val();
        logic signed [DATA_W-1:0] v;
        case ($urandom_range(0, 15))
            0:       v = -128;
            1:       v = 0;
            2:       v = 127;
            default: v = DATA_W'($urandom());
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (val_o !== 1'b0) begin
            errors++; $display("FAIL reset_val_o: got %0b expected 0", val_o);
        end
        checks++;
        if (into_atan_poly !== '0) begin
            errors++; $display("FAIL reset_ratio: got %0d expected 0", into_atan_poly);
        end
        checks++;
        if (case_flag !== 3'b000) begin
            errors++; $display("FAIL reset_flag: got %03b expected 000", case_flag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_i = 1'b1;
        #1;
        checks++;
        if (rdy_o !== 1'b1) begin
            errors++; $display("FAIL reset_rdy_o: got %0b expected 1", rdy_o);
        end
        $display("reset: val_o=%0b ratio=%0d flag=%03b rdy_o=%0b", val_o, into_atan_poly, case_flag, rdy_o);
    endtask

    task automatic test_single(input logic signed [DATA_W-1:0] re,
                               input logic signed [DATA_W-1:0] im,
                               input logic [FRAC_W-1:0]        exp_ratio,
                               input logic [2:0]               exp_flag,
                               input string                    tag);
        int lat;
        bit seen;
        @(posedge clk); #1;
        real_i = re;
        imag_i = im;
        val_i  = 1'b1;
        rdy_i  = 1'b1;
        lat    = 0;
        seen   = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            val_i = 1'b0;
            lat++;
            if (val_o) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != LAT_EXP) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, lat, LAT_EXP);
        end
        checks++;
        if (into_atan_poly !== exp_ratio) begin
            errors++; $display("FAIL %s_ratio: got %0d expected %0d", tag, into_atan_poly, exp_ratio);
        end
        checks++;
        if (case_flag !== exp_flag) begin
            errors++; $display("FAIL %s_flag: got %03b expected %03b", tag, case_flag, exp_flag);
        end
        $display("%s: re=%0d im=%0d ratio=%0d flag=%03b lat=%0d", tag, re, im, into_atan_poly, case_flag, lat);
    endtask

    task automatic test_directed();
        test_single(8'sd64,   8'sd32,   8'd128, 3'b000, "d_64_32");
        test_single(8'sd16,  -8'sd48,   8'd85,  3'b101, "d_16_m48");
        test_single(-8'sd128, -8'sd128, 8'd255, 3'b011, "d_m128_m128");
        test_single(8'sd0,    8'sd0,    8'd0,   3'b000, "d_zero");
    endtask

    task automatic test_stream();
        int   sent, recv, cyc, burst, idle_hits;
        bit   stall_prev, took;
        logic [FRAC_W-1:0] held_r;
        logic [2:0]        held_f;
        exp_t e;
        sent = 0; recv = 0; cyc = 0; burst = 0; stall_prev = 1'b0;
        held_r = '0; held_f = '0;
        sb.delete();
        @(posedge clk); #1;
        real_i = rand_val();
        imag_i = rand_val();
        val_i  = 1'b1;
        rdy_i  = 1'b1;
        while (recv < N_STREAM && cyc < 20000) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (val_o !== 1'b1 || into_atan_poly !== held_r || case_flag !== held_f) begin
                    errors++;
                    $display("FAIL stream_hold: got val=%0b r=%0d f=%03b expected val=1 r=%0d f=%03b",
                             val_o, into_atan_poly, case_flag, held_r, held_f);
                end
            end
            stall_prev = val_o && !rdy_i;
            held_r = into_atan_poly;
            held_f = case_flag;
            if (val_o && rdy_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got output r=%0d f=%03b expected none", into_atan_poly, case_flag);
                end else begin
                    e = sb.pop_front();
                    if (into_atan_poly !== e.ratio || case_flag !== e.flag) begin
                        errors++;
                        $display("FAIL stream_data #%0d: got r=%0d f=%03b expected r=%0d f=%03b",
                                 recv, into_atan_poly, case_flag, e.ratio, e.flag);
                    end
                    $display("stream out #%0d: ratio=%0d flag=%03b", recv, into_atan_poly, case_flag);
                end
                recv++;
            end
            took = val_i && rdy_o;
            if (took) begin
                sb.push_back(model(real_i, imag_i));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                if (sent < N_STREAM) begin
                    real_i = rand_val();
                    imag_i = ($urandom_range(0, 15) == 0) ? real_i : rand_val();
                end else begin
                    val_i = 1'b0;
                end
            end
            if (burst > 0) begin
                rdy_i = 1'b0;
                burst--;
            end else begin
                case ($urandom_range(0, 9))
                    0:       begin rdy_i = 1'b0; burst = 4; end
                    1, 2, 3: rdy_i = 1'b0;
                    default: rdy_i = 1'b1;
                endcase
            end
        end
        checks++;
        if (recv != N_STREAM || sent != N_STREAM) begin
            errors++; $display("FAIL stream_count: got sent=%0d recv=%0d expected %0d", sent, recv, N_STREAM);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL stream_pending: got %0d expected 0", sb.size());
        end
        val_i = 1'b0;
        rdy_i = 1'b1;
        idle_hits = 0;
        repeat (LAT_EXP + 4) begin
            @(posedge clk); #1;
            if (val_o) idle_hits++;
        end
        checks++;
        if (idle_hits != 0) begin
            errors++; $display("FAIL stream_dup: got %0d extra outputs expected 0", idle_hits);
        end
        $display("stream: sent=%0d recv=%0d cycles=%0d", sent, recv, cyc);
    endtask

    task automatic test_reset_flush();
        int seen;
        @(posedge clk); #1;
        rdy_i = 1'b0;
        val_i = 1'b1;
        repeat (LAT_EXP + 3) begin
            real_i = rand_val();
            imag_i = rand_val();
            @(posedge clk); #1;
        end
        checks++;
        if (val_o !== 1'b1) begin
            errors++; $display("FAIL flush_fill: got val_o=%0b expected 1", val_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (val_o !== 1'b0) begin
            errors++; $display("FAIL flush_async_val: got %0b expected 0", val_o);
        end
        checks++;
        if (into_atan_poly !== '0 || case_flag !== 3'b000) begin
            errors++; $display("FAIL flush_async_data: got r=%0d f=%03b expected 0 000", into_atan_poly, case_flag);
        end
        checks++;
        if (rdy_o !== 1'b1) begin
            errors++; $display("FAIL flush_rdy_o: got %0b expected 1", rdy_o);
        end
        val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_i = 1'b1;
        seen  = 0;
        repeat (LAT_EXP + 4) begin
            @(posedge clk); #1;
            if (val_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_stale: got %0d outputs expected 0", seen);
        end
        $display("flush: stale outputs after release=%0d", seen);
        test_single(8'sd100, -8'sd25, 8'd64, 3'b001, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/octant_reduce_pipe.md
Name: octant_reduce_pipe

Overview:
- Parametrised successor to the fixed 8-bit pattern-match stage in the atan datapath.
- Takes a signed complex sample (real, imag) and folds it into the first half-octant. Emits the fractional ratio min(|re|,|im|)/max(|re|,|im|) for the atan polynomial, plus a 3-bit octant flag for final angle reconstruction.
- Fully pipelined (one sample per cycle) with a restoring divider, one stage per quotient bit.
- Adds valid/ready backpressure and exact division, neither of which the previous stage had.

Parameters:
- DATA_W, 8, width of signed real_i/imag_i (two's complement).
- FRAC_W, 8, width of unsigned fractional ratio into_atan_poly (Q0.FRAC_W).
- LAT, FRAC_W+2 (derived, localparam), input-to-output latency in enabled cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- val_i  in  1  input sample valid.
- rdy_o  out  1  block can accept a sample this cycle.
- real_i  in  DATA_W  signed real part.
- imag_i  in  DATA_W  signed imaginary part.
- val_o  out  1  output valid.
- rdy_i  in  1  downstream accepts output.
- into_atan_poly  out  FRAC_W  ratio, unsigned Q0.FRAC_W.
- case_flag  out  3  octant flag {swap, re_neg, im_neg}.

Behaviour:
- Reset (rst_n low, async): all pipeline valid bits, val_o, into_atan_poly and case_flag clear to 0; rdy_o reads 1 once out of reset.
- Global enable: en = rdy_i | ~val_o; rdy_o = en.
  - Input transfer when val_i & rdy_o. Output transfer when val_o & rdy_i.
  - When en=0 every stage holds, including data and valid. No sample is dropped or duplicated.
- Stage 0 (magnitude/compare):
  - am = |real_i|, bm = |imag_i|, held in DATA_W-bit unsigned. The most negative value maps to 2^(DATA_W-1) with no overflow.
  - re_neg = real_i[MSB]; im_neg = imag_i[MSB].
  - swap = (bm > am), strict.
  - num = swap ? am : bm; den = swap ? bm : am.
- Stages 1..FRAC_W (restoring division): each stage produces one quotient bit MSB-first.
  - rem' = 2*rem, then if rem' >= den: rem' -= den and bit = 1.
  - Remainder width is DATA_W+1.
  - Flags and valid travel alongside the data.
- Output stage registers the results:
  - q = floor(num*2^FRAC_W/den).
  - num==den gives q = 2^FRAC_W, which is saturated to 2^FRAC_W-1.
  - den==0 (zero input) forces q=0, flag=000.
- Latency: first val_o exactly LAT enabled cycles after the input transfer. Throughput 1 sample/cycle when rdy_i=1.
- Ordering: strict FIFO order, no reordering.
- Reset mid-operation flushes all in-flight samples. No output appears for them after reset release.
- Outputs are stable while val_o=1 and rdy_i=0.

Optional Feature:
- Macro OCTANT_ROUND_EN.
- Defined:
  - One extra divider stage computes FRAC_W+1 quotient bits; ratio = (q+1)>>1, round-half-up.
  - Saturation to 2^FRAC_W-1 as above.
  - LAT becomes FRAC_W+3.
- Undefined: truncating quotient, LAT = FRAC_W+2.

Decomposition:
- Package octant_pkg holds:
  - flag bit indices FLAG_SWAP=2, FLAG_RE_NEG=1, FLAG_IM_NEG=0;
  - function computing LAT from FRAC_W and the macro;
  - saturation constant helper.
- One sub-module, octant_div_stage: parametrised on DATA_W. Registered with en; takes rem, den, partial quotient, flags and valid, and emits the same set one bit further along. The top instantiates it in a generate loop.

Test Plan:
- DATA_W=8, FRAC_W=8, truncate: real=64, imag=32 -> into_atan_poly=128, case_flag=000, val_o exactly 10 cycles after input.
- real=16, imag=-48 -> ratio 85 (0x55), case_flag=101. With OCTANT_ROUND_EN also 85, latency 11.
- real=-128, imag=-128 -> ratio 255 (saturated), case_flag=011 (no swap on equality). real=0, imag=0 -> ratio 0, flag 000.
- Stream 1024 random samples with val_i=1 continuously, rdy_i toggled randomly (including 5-cycle low bursts):
  - outputs match a C/scoreboard model in order;
  - count=1024; no drops or duplicates;
  - outputs held stable while rdy_i=0.
- Assert rst_n low for 2 cycles while 6 samples are in flight -> val_o=0 immediately (async). After release, only post-reset samples appear, first at LAT cycles.
